// File: rtl/mem_check_scanner.sv
// Memory self-check scanner: after halt, reads a table of (addr, exp, mask) entries and reports results.
// Optional halt-wait timeout is compiled in with `define MEM_CHECK_TIMEOUT_EN.
module mem_check_scanner #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned NUM_CHECKS  = 8,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic              halt_f,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_exp,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [IDX_W:0]    mismatch_cnt,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_data,
  output logic              timeout
);

  localparam int unsigned MC_W        = IDX_W + 1;
  localparam int unsigned CNT_MAX     = (SETTLE_CYC > MEM_LATENCY) ? SETTLE_CYC : MEM_LATENCY;
  localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;
  localparam int unsigned LAT_LAST    = MEM_LATENCY - 1;

  if (IDX_W != $clog2(NUM_CHECKS) || MEM_LATENCY < 1 || MEM_LATENCY > 4 || TIMEOUT_CYC == 0) begin : g_bad_cfg
    $error("mem_check_scanner: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    SETTLE = 3'd2,
    READ   = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] mask;
  } entry_t;

  entry_t            tbl [NUM_CHECKS];
  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [MC_W-1:0]   mcnt_n;
  logic [IDX_W-1:0]  ffi_n;
  logic [DATA_W-1:0] ffd_n;
  logic              to_n;
  logic              rd_en_n, busy_n, done_n, pass_n, fail_n;
  logic [ADDR_W-1:0] rd_addr_n;
  logic              tbl_we_c;

`ifdef MEM_CHECK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] tcnt, tcnt_n;
`endif

  // Table writes only land while the scanner is not busy.
  assign tbl_we_c = clk_en && cfg_we && (state == IDLE || state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CHECKS; i++) tbl[i] <= '0;
    end else if (tbl_we_c) begin
      tbl[cfg_idx].addr <= cfg_addr;
      tbl[cfg_idx].exp  <= cfg_exp;
      tbl[cfg_idx].mask <= cfg_mask;
    end
  end

  // Next-state, scan datapath and registered-output next values.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    mcnt_n  = mismatch_cnt;
    ffi_n   = first_fail_idx;
    ffd_n   = first_fail_data;
`ifdef MEM_CHECK_TIMEOUT_EN
    to_n    = timeout;
    tcnt_n  = tcnt;
`else
    to_n    = 1'b0;
`endif

    case (state)
      IDLE, DONE: begin
        if (start) begin
          mcnt_n  = '0;
          ffi_n   = '0;
          ffd_n   = '0;
          to_n    = 1'b0;
          cnt_n   = '0;
          idx_n   = '0;
`ifdef MEM_CHECK_TIMEOUT_EN
          tcnt_n  = '0;
`endif
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (halt_f) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = (SETTLE_CYC == 0) ? READ : SETTLE;
        end
`ifdef MEM_CHECK_TIMEOUT_EN
        else if (tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
          to_n    = 1'b1;
          state_n = DONE;
        end else begin
          tcnt_n = tcnt + TO_W'(1);
        end
`endif
      end
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_LAST)) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = READ;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      READ: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == CNT_W'(LAT_LAST)) begin
          cnt_n = '0;
          if (((mem_rd_data ^ tbl[idx].exp) & tbl[idx].mask) != '0) begin
            mcnt_n = mismatch_cnt + MC_W'(1);
            if (mismatch_cnt == '0) begin
              ffi_n = idx;
              ffd_n = mem_rd_data;
            end
          end
          if (idx == IDX_W'(NUM_CHECKS - 1)) begin
            state_n = DONE;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = READ;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    rd_en_n   = (state_n == READ);
    rd_addr_n = (state_n == READ) ? tbl[idx_n].addr : mem_rd_addr;
    busy_n    = (state_n inside {ARMED, SETTLE, READ, WAIT});
    done_n    = (state_n == DONE);
    pass_n    = done_n && (mcnt_n == '0) && !to_n;
    fail_n    = done_n && !pass_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      idx             <= '0;
      mem_rd_en       <= 1'b0;
      mem_rd_addr     <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail            <= 1'b0;
      mismatch_cnt    <= '0;
      first_fail_idx  <= '0;
      first_fail_data <= '0;
    end else if (clk_en) begin
      state           <= state_n;
      cnt             <= cnt_n;
      idx             <= idx_n;
      mem_rd_en       <= rd_en_n;
      mem_rd_addr     <= rd_addr_n;
      busy            <= busy_n;
      done            <= done_n;
      pass            <= pass_n;
      fail            <= fail_n;
      mismatch_cnt    <= mcnt_n;
      first_fail_idx  <= ffi_n;
      first_fail_data <= ffd_n;
    end
  end

`ifdef MEM_CHECK_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt    <= '0;
      timeout <= 1'b0;
    end else if (clk_en) begin
      tcnt    <= tcnt_n;
      timeout <= to_n;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mem_check_scanner.sv
// Self-checking bench for mem_check_scanner: table-driven scans plus reset / clk_en corner sequences.
module tb_mem_check_scanner;

  logic        clk = 1'b0;
  logic        rst_n, clk_en, start, halt_f, cfg_we;
  logic [2:0]  cfg_idx;
  logic [13:0] cfg_addr;
  logic [31:0] cfg_exp, cfg_mask;
  logic        mem_rd_en;
  logic [13:0] mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        busy, done, pass, fail, timeout;
  logic [3:0]  mismatch_cnt;
  logic [2:0]  first_fail_idx;
  logic [31:0] first_fail_data;

  int tests  = 0;
  int failed = 0;
  int rd_count = 0;

  logic [31:0] mem [0:16383];

  typedef struct {
    int ia; logic [13:0] aa; logic [31:0] ea, ma, da;
    int ib; logic [13:0] ab; logic [31:0] eb, mb, db;
    logic pass; logic [3:0] mcnt; logic [2:0] ffi; logic [31:0] ffd;
  } vec_t;

  typedef struct {
    logic pass; logic [3:0] mcnt; logic [2:0] ffi; logic [31:0] ffd; int lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  mem_check_scanner dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start), .halt_f(halt_f),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_exp(cfg_exp), .cfg_mask(cfg_mask),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .mismatch_cnt(mismatch_cnt),
    .first_fail_idx(first_fail_idx), .first_fail_data(first_fail_data), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Latency-1 memory stalled by the same clock enable.
  always @(posedge clk) begin
    if (clk_en && mem_rd_en) begin
      mem_rd_data <= mem[mem_rd_addr];
      rd_count    <= rd_count + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic cfg_write(input int i, input logic [13:0] a, input logic [31:0] e, input logic [31:0] m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = a; cfg_exp = e; cfg_mask = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < 8; i++) begin
      cfg_write(i, 14'(1000 + i), 32'h0, 32'h0);
      mem[1000 + i] = $urandom;
    end
    cfg_write(v.ia, v.aa, v.ea, v.ma);
    mem[v.aa] = v.da;
    if (v.ib >= 0) begin
      cfg_write(v.ib, v.ab, v.eb, v.mb);
      mem[v.ab] = v.db;
    end
  endtask

  // One scan: start, halt, then measure done latency from the halt-sampling edge.
  task automatic run_scan(input exp_t e, input bit stall, input bit wr_with_start);
    int   n;
    int   rd0;
    bit   seen;
    exp_t x;
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin
      cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 14'd100; cfg_exp = 32'h33; cfg_mask = 32'hFFFFFFFF;
    end
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; cfg_we = 1'b0;
    repeat (3) @(negedge clk);
    check("armed_busy", busy, 1'b1);
    check("armed_no_read", mem_rd_en, 1'b0);
    check("armed_done_low", done, 1'b0);
    rd0 = rd_count;
    halt_f = 1'b1;
    @(posedge clk);
    n = 0; seen = 0;
    while (n < 200) begin
      #1;
      if (done) begin seen = 1; break; end
      if (n == 4) halt_f = 1'b0;
      if (stall && n == 3) clk_en = 1'b0;
      if (stall && n == 8) clk_en = 1'b1;
      if (stall && n == 10) begin
        start = 1'b1;
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_addr = 14'd20; cfg_exp = 32'h2; cfg_mask = 32'h0;
      end
      if (stall && n == 11) begin start = 1'b0; cfg_we = 1'b0; end
      @(posedge clk);
      n++;
    end
    halt_f = 1'b0; start = 1'b0; cfg_we = 1'b0; clk_en = 1'b1;
    x = sb.pop_front();
    check("done_seen", 32'(seen), 32'd1);
    if (!seen) return;
    check("latency", n, x.lat);
    check("pass", pass, x.pass);
    check("fail", fail, !x.pass);
    check("mismatch_cnt", mismatch_cnt, x.mcnt);
    if (!x.pass) begin
      check("first_fail_idx", first_fail_idx, x.ffi);
      check("first_fail_data", first_fail_data, x.ffd);
    end
    check("timeout", timeout, 1'b0);
    check("busy_at_done", busy, 1'b0);
    check("read_pulses", rd_count - rd0, 8);
    repeat (3) @(negedge clk);
    check("done_held", done, 1'b1);
    check("mcnt_held", mismatch_cnt, x.mcnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    exp_t e;
    int   k;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    rst_n = 1'b0; clk_en = 1'b1; start = 1'b0; halt_f = 1'b0; cfg_we = 1'b0;
    cfg_idx = '0; cfg_addr = '0; cfg_exp = '0; cfg_mask = '0;

    vecs[0] = '{0, 14'd100, 32'h32, 32'hFFFFFFFF, 32'h32, -1, 14'd0, 32'h0, 32'h0, 32'h0, 1'b1, 4'd0, 3'd0, 32'h0};
    vecs[1] = '{1, 14'd5, 32'h0000AB00, 32'h0000FF00, 32'h1234AB99, -1, 14'd0, 32'h0, 32'h0, 32'h0, 1'b1, 4'd0, 3'd0, 32'h0};
    vecs[2] = '{2, 14'd20, 32'h1, 32'hFFFFFFFF, 32'h2, 6, 14'd21, 32'h7, 32'hFFFFFFFF, 32'h0, 1'b0, 4'd2, 3'd2, 32'h2};
    vecs[3] = '{7, 14'd30, 32'hF0, 32'hF0, 32'h0F, -1, 14'd0, 32'h0, 32'h0, 32'h0, 1'b0, 4'd1, 3'd7, 32'h0F};
    vecs[4] = '{3, 14'd40, 32'hDEAD, 32'h0, 32'h0, 5, 14'd41, 32'h5, 32'h4, 32'h4, 1'b1, 4'd0, 3'd0, 32'h0};
    vecs[5] = '{0, 14'd50, 32'h0, 32'hFFFFFFFF, 32'h80000000, 4, 14'd51, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 4'd2, 3'd0, 32'h80000000};

    #12;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_fail", fail, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_rd_addr", mem_rd_addr, 14'd0);
    check("rst_mcnt", mismatch_cnt, 4'd0);
    check("rst_timeout", timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      load_vec(v);
      e = '{v.pass, v.mcnt, v.ffi, v.ffd, 18};
      run_scan(e, 1'b0, 1'b0);
    end

    // Stall 5 cycles mid-scan; start and cfg_we during the scan must be ignored.
    load_vec(vecs[2]);
    e = '{1'b0, 4'd2, 3'd2, 32'h2, 23};
    run_scan(e, 1'b1, 1'b0);

    // Write landing in the start cycle is used by that scan.
    load_vec(vecs[0]);
    e = '{1'b0, 4'd1, 3'd0, 32'h32, 18};
    run_scan(e, 1'b0, 1'b1);

    // Reset while waiting on read data.
    load_vec(vecs[0]);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; halt_f = 1'b1;
    k = 0;
    while (k < 50) begin
      @(posedge clk); #1;
      if (mem_rd_en) break;
      k++;
    end
    check("reach_read", 32'(k < 50), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_rd_en", mem_rd_en, 1'b0);
    halt_f = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle_busy", busy, 1'b0);
    check("post_rst_idle_done", done, 1'b0);

    // Cleared table: every entry disabled, so a bad mem[100] must not matter.
    mem[100] = 32'h0;
    e = '{1'b1, 4'd0, 3'd0, 32'h0, 18};
    run_scan(e, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
